multi_player_motion: RTL and testbench

- Parametrised successor to the single-character FireBoy motion block. It moves NUM_PLAYERS characters (default 2: Fireboy and Icegirl) from shared USB keycode slots, with jump and gravity physics.
- It runs in the 50 MHz domain and updates once per VGA frame.
- It drives per-player position buses and per-pixel hit flags that feed color_mapper and the collision/bg logic.

---
 rtl/multi_player_motion.sv | 246 ++++++++++++++++++++++++
 tb/tb_multi_player_motion.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_player_motion.sv
// Frame-rate motion for NUM_PLAYERS sprites: keycode decode, jump/gravity physics,
// and per-pixel hit flags. Players are updated one per Clk cycle after each frame tick.
module multi_player_motion #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned KEY_SLOTS   = 4,
  parameter logic [NUM_PLAYERS*8-1:0]  KEY_UP    = {8'h52, 8'h1A},
  parameter logic [NUM_PLAYERS*8-1:0]  KEY_LEFT  = {8'h50, 8'h04},
  parameter logic [NUM_PLAYERS*8-1:0]  KEY_RIGHT = {8'h4F, 8'h07},
  parameter logic [NUM_PLAYERS*10-1:0] SPAWN_X   = {10'd560, 10'd40},
  parameter logic [NUM_PLAYERS*10-1:0] SPAWN_Y   = {10'd440, 10'd440},
  parameter int unsigned SIZE    = 16,
  parameter int unsigned X_MAX   = 639,
  parameter int unsigned Y_MAX   = 479,
  parameter int unsigned STEP_X  = 2,
  parameter int unsigned JUMP_V  = 8,
  parameter int unsigned GRAVITY = 1,
  parameter int unsigned VMAX    = 8
) (
  input  logic                            Clk,
  input  logic                            Reset_n,
  input  logic                            frame_clk,
  input  logic [KEY_SLOTS*8-1:0]          keycodes,
  input  logic                            revive,
  input  logic                            freeze,
  input  logic [NUM_PLAYERS-1:0]          on_ground,
  input  logic [NUM_PLAYERS-1:0]          blocked_up,
  input  logic [NUM_PLAYERS-1:0]          blocked_left,
  input  logic [NUM_PLAYERS-1:0]          blocked_right,
  input  logic [9:0]                      DrawX,
  input  logic [9:0]                      DrawY,
  output logic [NUM_PLAYERS*10-1:0]       pos_x,
  output logic [NUM_PLAYERS*10-1:0]       pos_y,
  output logic [NUM_PLAYERS-1:0]          airborne,
  output logic [NUM_PLAYERS-1:0]          is_player,
  output logic                            hit_valid,
  output logic [$clog2(NUM_PLAYERS)-1:0]  hit_idx,
  output logic [$clog2(SIZE)-1:0]         off_x,
  output logic [$clog2(SIZE)-1:0]         off_y,
  output logic                            update_done
);

  localparam int unsigned IW = $clog2(NUM_PLAYERS);
  localparam int unsigned OW = $clog2(SIZE);
  localparam logic [10:0] X_LIM  = 11'(X_MAX - SIZE + 1);
  localparam logic [10:0] Y_LIM  = 11'(Y_MAX - SIZE + 1);
  localparam logic [10:0] STEP   = 11'(STEP_X);
  localparam logic [10:0] SIZE11 = 11'(SIZE);
  localparam logic [5:0]  JUMP6  = 6'(JUMP_V);
  localparam logic [5:0]  GRAV6  = 6'(GRAVITY);
  localparam logic [5:0]  VMAX6  = 6'(VMAX);

  typedef enum logic [1:0] {GROUNDED, RISING, FALLING} vstate_e;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} sweep_e;

  logic [9:0] px [NUM_PLAYERS];
  logic [9:0] py [NUM_PLAYERS];
  logic [5:0] vy [NUM_PLAYERS];
  vstate_e    vs [NUM_PLAYERS];

  // frame_clk synchroniser and rising-edge detect
  logic [2:0] fsync;
  logic       tick;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) fsync <= '0;
    else          fsync <= {fsync[1:0], frame_clk};
  end

  assign tick = fsync[1] & ~fsync[2];

  sweep_e         sweep_q, sweep_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           upd_en;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sweep_q <= IDLE;
      idx_q   <= '0;
    end else begin
      sweep_q <= sweep_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    sweep_d = sweep_q;
    idx_d   = idx_q;
    upd_en  = 1'b0;
    case (sweep_q)
      IDLE: begin
        if (tick && !freeze) begin
          sweep_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        upd_en = 1'b1;
        if (idx_q == IW'(NUM_PLAYERS - 1)) sweep_d = DONE;
        else                               idx_d   = idx_q + 1'b1;
      end
      DONE:    sweep_d = IDLE;
      default: sweep_d = IDLE;
    endcase
    // revive aborts the sweep and swallows any coincident tick
    if (revive) begin
      sweep_d = IDLE;
      idx_d   = '0;
      upd_en  = 1'b0;
    end
  end

  assign update_done = (sweep_q == DONE);

  function automatic logic key_down(input logic [KEY_SLOTS*8-1:0] keys,
                                    input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int unsigned s = 0; s < KEY_SLOTS; s++)
      if (keys[s*8 +: 8] == code) hit = 1'b1;
    return hit;
  endfunction

  int unsigned sel;
  logic [10:0] cur_x, cur_y, nx, ny;
  logic [5:0]  cur_vy, nvy;
  vstate_e     cur_vs, nvs;
  logic        k_up, k_left, k_right;

  always_comb begin
    sel     = 32'(idx_q);
    cur_x   = {1'b0, px[idx_q]};
    cur_y   = {1'b0, py[idx_q]};
    cur_vy  = vy[idx_q];
    cur_vs  = vs[idx_q];
    k_up    = key_down(keycodes, KEY_UP[sel*8 +: 8]);
    k_left  = key_down(keycodes, KEY_LEFT[sel*8 +: 8]);
    k_right = key_down(keycodes, KEY_RIGHT[sel*8 +: 8]);

    nx = cur_x;
    if (k_left && !k_right && !blocked_left[idx_q])
      nx = (cur_x >= STEP) ? cur_x - STEP : '0;
    else if (k_right && !k_left && !blocked_right[idx_q])
      nx = (cur_x + STEP > X_LIM) ? X_LIM : cur_x + STEP;

    ny  = cur_y;
    nvy = cur_vy;
    nvs = cur_vs;
    case (cur_vs)
      GROUNDED: begin
        if (!on_ground[idx_q]) begin
          nvs = FALLING;
          nvy = '0;
        end else if (k_up && !blocked_up[idx_q]) begin
          nvs = RISING;
          nvy = JUMP6;
        end
      end
      RISING: begin
        if (blocked_up[idx_q]) begin
          nvs = FALLING;
          nvy = '0;
        end else begin
          ny = (cur_y >= {5'b0, cur_vy}) ? cur_y - {5'b0, cur_vy} : '0;
          if (cur_vy <= GRAV6) begin
            nvy = '0;
            nvs = FALLING;
          end else begin
            nvy = cur_vy - GRAV6;
          end
        end
      end
      FALLING: begin
        if (on_ground[idx_q]) begin
          nvs = GROUNDED;
          nvy = '0;
        end else begin
          ny  = (cur_y + {5'b0, cur_vy} > Y_LIM) ? Y_LIM : cur_y + {5'b0, cur_vy};
          nvy = ({1'b0, cur_vy} + {1'b0, GRAV6} >= {1'b0, VMAX6}) ? VMAX6 : cur_vy + GRAV6;
        end
      end
      default: begin
        nvs = FALLING;
        nvy = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        px[i] <= SPAWN_X[i*10 +: 10];
        py[i] <= SPAWN_Y[i*10 +: 10];
        vs[i] <= FALLING;
        vy[i] <= '0;
      end
    end else if (revive) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        px[i] <= SPAWN_X[i*10 +: 10];
        py[i] <= SPAWN_Y[i*10 +: 10];
        vs[i] <= FALLING;
        vy[i] <= '0;
      end
    end else if (upd_en) begin
      px[idx_q] <= nx[9:0];
      py[idx_q] <= ny[9:0];
      vs[idx_q] <= nvs;
      vy[idx_q] <= nvy;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      pos_x[i*10 +: 10] = px[i];
      pos_y[i*10 +: 10] = py[i];
      airborne[i]       = (vs[i] != GROUNDED);
    end
  end

  logic       found;
  logic [9:0] dx, dy;

  always_comb begin
    is_player = '0;
    hit_idx   = '0;
    off_x     = '0;
    off_y     = '0;
    found     = 1'b0;
    dx        = '0;
    dy        = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      is_player[i] = ({1'b0, DrawX} >= {1'b0, px[i]}) && ({1'b0, DrawX} < {1'b0, px[i]} + SIZE11) &&
                     ({1'b0, DrawY} >= {1'b0, py[i]}) && ({1'b0, DrawY} < {1'b0, py[i]} + SIZE11);
      if (is_player[i] && !found) begin
        found   = 1'b1;
        hit_idx = IW'(i);
        dx      = DrawX - px[i];
        dy      = DrawY - py[i];
        off_x   = dx[OW-1:0];
        off_y   = dy[OW-1:0];
      end
    end
  end

  assign hit_valid = |is_player;

endmodule

// File: tb/tb_multi_player_motion.sv
// Randomised scoreboard bench for multi_player_motion with an arithmetic reference model.
module tb_multi_player_motion;
  localparam int NP = 2;
  localparam int SZ = 16;
  localparam int XL = 624;
  localparam int YL = 464;

  logic        Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
  logic [31:0] keycodes = '0;
  logic        revive = 1'b0, freeze = 1'b0;
  logic [1:0]  on_ground = '0, blocked_up = '0, blocked_left = '0, blocked_right = '0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic [19:0] pos_x, pos_y;
  logic [1:0]  airborne, is_player;
  logic        hit_valid, update_done;
  logic [0:0]  hit_idx;
  logic [3:0]  off_x, off_y;

  multi_player_motion #(.NUM_PLAYERS(NP), .KEY_SLOTS(4), .SIZE(SZ)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycodes(keycodes),
    .revive(revive), .freeze(freeze), .on_ground(on_ground), .blocked_up(blocked_up),
    .blocked_left(blocked_left), .blocked_right(blocked_right), .DrawX(DrawX), .DrawY(DrawY),
    .pos_x(pos_x), .pos_y(pos_y), .airborne(airborne), .is_player(is_player),
    .hit_valid(hit_valid), .hit_idx(hit_idx), .off_x(off_x), .off_y(off_y),
    .update_done(update_done));

  always #10 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  // model: state 0 = grounded, 1 = rising, 2 = falling
  int mx[NP], my[NP], mst[NP], mvy[NP];
  int kup[NP]   = '{8'h1A, 8'h52};
  int kleft[NP] = '{8'h04, 8'h50};
  int kright[NP]= '{8'h07, 8'h4F};
  int spx[NP]   = '{40, 560};

  typedef struct packed { logic [19:0] x; logic [19:0] y; logic [1:0] air; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit pressed(input int code);
    for (int s = 0; s < 4; s++) if (int'(keycodes[s*8 +: 8]) == code) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_spawn();
    for (int p = 0; p < NP; p++) begin
      mx[p] = spx[p]; my[p] = 440; mst[p] = 2; mvy[p] = 0;
    end
  endfunction

  function automatic void model_player(input int p);
    bit l, r, u;
    l = pressed(kleft[p]); r = pressed(kright[p]); u = pressed(kup[p]);
    if (l && !r && !blocked_left[p])       mx[p] = (mx[p] - 2 < 0) ? 0 : mx[p] - 2;
    else if (r && !l && !blocked_right[p]) mx[p] = (mx[p] + 2 > XL) ? XL : mx[p] + 2;
    if (mst[p] == 0) begin
      if (!on_ground[p]) begin mst[p] = 2; mvy[p] = 0; end
      else if (u && !blocked_up[p]) begin mst[p] = 1; mvy[p] = 8; end
    end else if (mst[p] == 1) begin
      if (blocked_up[p]) begin mst[p] = 2; mvy[p] = 0; end
      else begin
        my[p] = (my[p] - mvy[p] < 0) ? 0 : my[p] - mvy[p];
        mvy[p] = mvy[p] - 1;
        if (mvy[p] == 0) mst[p] = 2;
      end
    end else begin
      if (on_ground[p]) begin mst[p] = 0; mvy[p] = 0; end
      else begin
        my[p]  = (my[p] + mvy[p] > YL) ? YL : my[p] + mvy[p];
        mvy[p] = (mvy[p] + 1 > 8) ? 8 : mvy[p] + 1;
      end
    end
  endfunction

  function automatic exp_t model_snapshot();
    exp_t e;
    e.x   = {10'(mx[1]), 10'(mx[0])};
    e.y   = {10'(my[1]), 10'(my[0])};
    e.air = {mst[1] != 0, mst[0] != 0};
    return e;
  endfunction

  always @(negedge Clk) begin
    if (Reset_n && update_done) begin
      check("done_width", int'(prev_done), 0);
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_pos_x", int'(pos_x), int'(mon_e.x));
        check("sb_pos_y", int'(pos_y), int'(mon_e.y));
        check("sb_airborne", int'(airborne), int'(mon_e.air));
      end
    end
    prev_done = update_done;
  end

  task automatic run_frame(input bit chk_lat);
    bit seen;
    int lat;
    if (!freeze) begin
      for (int p = 0; p < NP; p++) model_player(p);
      sb.push_back(model_snapshot());
    end
    @(posedge Clk); #1 frame_clk = 1'b1;
    seen = 1'b0; lat = 0;
    for (int c = 1; c <= 12 && !seen; c++) begin
      @(negedge Clk);
      if (update_done) begin seen = 1'b1; lat = c; end
    end
    if (freeze) check("freeze_no_done", int'(seen), 0);
    else begin
      check("done_seen", int'(seen), 1);
      if (chk_lat) check("latency", lat, 6);
    end
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic check_model_pos(input string tag);
    exp_t e;
    e = model_snapshot();
    check({tag, "_x"}, int'(pos_x), int'(e.x));
    check({tag, "_y"}, int'(pos_y), int'(e.y));
    check({tag, "_air"}, int'(airborne), int'(e.air));
  endtask

  task automatic hit_check(input int x, input int y);
    int eis, eidx, eox, eoy;
    bit found;
    DrawX = 10'(x); DrawY = 10'(y);
    #1;
    eis = 0; eidx = 0; eox = 0; eoy = 0; found = 0;
    for (int p = 0; p < NP; p++) begin
      if (x >= mx[p] && x < mx[p] + SZ && y >= my[p] && y < my[p] + SZ) begin
        eis |= (1 << p);
        if (!found) begin found = 1; eidx = p; eox = x - mx[p]; eoy = y - my[p]; end
      end
    end
    check("is_player", int'(is_player), eis);
    check("hit_valid", int'(hit_valid), int'(found));
    check("hit_idx", int'(hit_idx), eidx);
    check("off_x", int'(off_x), eox);
    check("off_y", int'(off_y), eoy);
  endtask

  function automatic logic [7:0] rand_key();
    int codes[8] = '{8'h00, 8'h1A, 8'h52, 8'h04, 8'h50, 8'h07, 8'h4F, 8'h00};
    int k;
    k = int'($urandom_range(0, 8));
    if (k == 8) return 8'($urandom);
    return 8'(codes[k]);
  endfunction

  task automatic pulse_revive();
    @(posedge Clk); #1 revive = 1'b1;
    @(posedge Clk); #1 revive = 1'b0;
    model_spawn();
  endtask

  int jump_seq[8] = '{432, 425, 419, 414, 410, 407, 405, 404};
  int px_pt, py_pt, steps;

  initial begin
    model_spawn();
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_x0", int'(pos_x[9:0]), 40);
    check("rst_x1", int'(pos_x[19:10]), 560);
    check("rst_y0", int'(pos_y[9:0]), 440);
    check("rst_y1", int'(pos_y[19:10]), 440);
    check("rst_air", int'(airborne), 3);
    check("rst_done", int'(update_done), 0);
    hit_check(40, 440);

    // right key in slot 2, both land
    on_ground = 2'b11; keycodes = 32'h0007_0000;
    run_frame(1'b1);
    check("right_x0", int'(pos_x[9:0]), 42);
    check("right_x1", int'(pos_x[19:10]), 560);

    // jump for player 0
    keycodes = 32'h0000_001A;
    run_frame(1'b0);
    on_ground = 2'b10;
    for (int k = 0; k < 8; k++) begin
      run_frame(1'b0);
      check("jump_y", int'(pos_y[9:0]), jump_seq[k]);
    end
    check("jump_air", int'(airborne[0]), 1);

    // free fall, clamp at bottom
    on_ground = 2'b00; keycodes = '0;
    for (int k = 0; k < 25; k++) run_frame(1'b0);
    check("fall_clamp_y1", int'(pos_y[19:10]), YL);
    check("fall_clamp_y0", int'(pos_y[9:0]), YL);

    // left wall and opposing keys
    on_ground = 2'b11; keycodes = 32'h0000_0400;
    for (int k = 0; k < 25; k++) run_frame(1'b0);
    check("left_clamp", int'(pos_x[9:0]), 0);
    keycodes = 32'h0007_0004;
    run_frame(1'b0);
    check("both_keys", int'(pos_x[9:0]), 0);

    // right edge for player 1
    keycodes = 32'h4F00_0000;
    for (int k = 0; k < 35; k++) run_frame(1'b0);
    check("right_clamp", int'(pos_x[19:10]), XL);

    // freeze drops the tick
    keycodes = 32'h0000_0007; freeze = 1'b1;
    run_frame(1'b0);
    check_model_pos("freeze");
    freeze = 1'b0;

    // randomised frames
    for (int k = 0; k < 60; k++) begin
      for (int s = 0; s < 4; s++) keycodes[s*8 +: 8] = rand_key();
      on_ground     = 2'($urandom);
      blocked_up    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      blocked_left  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      blocked_right = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      run_frame(1'b0);
      for (int h = 0; h < 2; h++) begin
        px_pt = mx[h] + int'($urandom_range(0, SZ + 7)) - 4;
        py_pt = my[h] + int'($urandom_range(0, SZ + 7)) - 4;
        if (px_pt < 0) px_pt = 0;
        if (py_pt < 0) py_pt = 0;
        if (px_pt > 1023) px_pt = 1023;
        if (py_pt > 1023) py_pt = 1023;
        hit_check(px_pt, py_pt);
      end
    end
    blocked_up = '0; blocked_left = '0; blocked_right = '0;

    // walk players towards each other until the boxes overlap
    pulse_revive();
    check_model_pos("revive_idle");
    on_ground = 2'b11; keycodes = 32'h0000_5007;
    steps = 0;
    while ((mx[1] - mx[0] >= SZ) && steps < 200) begin
      run_frame(1'b0);
      steps++;
    end
    check("overlap_reached", int'(mx[1] - mx[0] < SZ), 1);
    hit_check(mx[1] + 1, my[0] + 1);
    check("overlap_both", int'(is_player), 3);
    check("overlap_idx", int'(hit_idx), 0);
    hit_check(mx[0] + SZ + 1, my[1] + 2);

    // revive during the first sweep cycle
    keycodes = 32'h0000_0007;
    @(posedge Clk); #1 frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 revive = 1'b1;
    @(posedge Clk); #1 revive = 1'b0;
    model_spawn();
    check_model_pos("revive_sweep");
    frame_clk = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    check_model_pos("revive_after");

    // reset in the middle of a sweep
    on_ground = 2'b00;
    run_frame(1'b0);
    @(posedge Clk); #1 frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #1 Reset_n = 1'b0; frame_clk = 1'b0;
    model_spawn();
    #1;
    check_model_pos("rst_sweep");
    @(posedge Clk); #1 Reset_n = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
    check_model_pos("rst_sweep_after");
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
